// File: rtl/ram_fifo_pkg.sv
// Shared defaults for the RAM-backed synchronous FIFO and its storage.
package ram_fifo_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 4;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// Simple dual-port RAM: synchronous write port, registered synchronous read port.
module ram_fifo_mem
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AddrWidth = DefAddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = fifo_depth(AddrWidth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_fifo_sync.sv
// Synchronous FIFO over a dual-port RAM with 1-cycle read latency.
// Optional sticky overflow/underflow flags: define RAM_FIFO_SYNC_ERR_FLAGS_EN.
module ram_fifo_sync
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DefDataWidth,
    parameter int unsigned ADDR_WIDTH        = DefAddrWidth,
    parameter int unsigned ALMOST_FULL_LEVEL = fifo_depth(ADDR_WIDTH) - 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oValid,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oOverflow,
    output logic                  oUnderflow,
    input  logic                  iClearFlags
);

    localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH+1)'(Depth);
    localparam logic [ADDR_WIDTH:0] CountAf   = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  full, empty, push_acc, pop_acc;

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so push is allowed when full if a pop is accepted.
    assign pop_acc  = iPop & ~empty;
    assign push_acc = iPush & (~full | pop_acc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = pop_acc;
        if (push_acc) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (pop_acc) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    ram_fifo_mem #(
        .DataWidth(DATA_WIDTH),
        .AddrWidth(ADDR_WIDTH)
    ) u_mem (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .we_i   (push_acc),
        .waddr_i(wptr_q),
        .wdata_i(iDataIn),
        .re_i   (pop_acc),
        .raddr_i(rptr_q),
        .rdata_o(oDataOut)
    );

`ifdef RAM_FIFO_SYNC_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        ovf_d = (ovf_q & ~iClearFlags) | (iPush & full & ~pop_acc);
        unf_d = (unf_q & ~iClearFlags) | (iPop & empty);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign oOverflow  = ovf_q;
    assign oUnderflow = unf_q;
`else
    logic unused_clear_flags;
    assign unused_clear_flags = iClearFlags;
    assign oOverflow          = 1'b0;
    assign oUnderflow         = 1'b0;
`endif

    assign oValid      = valid_q;
    assign oFull       = full;
    assign oEmpty      = empty;
    assign oAlmostFull = (count_q >= CountAf);
    assign oCount      = count_q;

endmodule

// File: tb/tb_ram_fifo_sync.sv
// Scoreboard bench for ram_fifo_sync: stimulus queues expected pops, a negedge monitor checks them.
module tb_ram_fifo_sync;

    localparam int unsigned Depth = 16;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iPush = 1'b0;
    logic [7:0] iDataIn = 8'h00;
    logic       iPop = 1'b0;
    logic       iClearFlags = 1'b0;
    logic [7:0] oDataOut;
    logic       oValid, oFull, oEmpty, oAlmostFull, oOverflow, oUnderflow;
    logic [4:0] oCount;

    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] last_dout = 8'h00;

    ram_fifo_sync u_dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iPush      (iPush),
        .iDataIn    (iDataIn),
        .iPop       (iPop),
        .oDataOut   (oDataOut),
        .oValid     (oValid),
        .oFull      (oFull),
        .oEmpty     (oEmpty),
        .oAlmostFull(oAlmostFull),
        .oCount     (oCount),
        .oOverflow  (oOverflow),
        .oUnderflow (oUnderflow),
        .iClearFlags(iClearFlags)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " count"}, 32'(oCount), 32'(mdl.size()));
        chk({tag, " full"}, 32'(oFull), 32'(mdl.size() == Depth));
        chk({tag, " empty"}, 32'(oEmpty), 32'(mdl.size() == 0));
        chk({tag, " almost_full"}, 32'(oAlmostFull), 32'(mdl.size() >= Depth - 2));
        chk({tag, " overflow"}, 32'(oOverflow), 32'(m_ovf));
        chk({tag, " underflow"}, 32'(oUnderflow), 32'(m_unf));
    endtask

    // One clock of stimulus; the model decides acceptance independently of the DUT.
    task automatic step(input string tag, input logic push, input logic [7:0] d,
                        input logic pop, input logic clr);
        bit pop_ok, push_ok;
        iPush = push; iDataIn = d; iPop = pop; iClearFlags = clr;
        pop_ok  = pop && (mdl.size() != 0);
        push_ok = push && ((mdl.size() < Depth) || pop_ok);
`ifdef RAM_FIFO_SYNC_ERR_FLAGS_EN
        m_ovf = (m_ovf && !clr) || (push && (mdl.size() == Depth) && !pop_ok);
        m_unf = (m_unf && !clr) || (pop && (mdl.size() == 0));
`endif
        if (pop_ok) exp_q.push_back(mdl.pop_front());
        if (push_ok) mdl.push_back(d);
        @(posedge Clock);
        #1;
        iPush = 1'b0; iPop = 1'b0; iClearFlags = 1'b0;
        chk_state(tag);
    endtask

    // Monitor: compares every presented word against the scoreboard and checks hold behaviour.
    always @(negedge Clock) begin
        if (!Reset) begin
            last_dout = 8'h00;
        end else if (oValid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_valid: got data 0x%0h, expected no output", oDataOut);
            end else begin
                last_dout = exp_q.pop_front();
                chk("pop_data", 32'(oDataOut), 32'(last_dout));
            end
        end else begin
            chk("hold_data", 32'(oDataOut), 32'(last_dout));
        end
    end

    initial begin
        // Reset state
        #1;
        chk("rst count", 32'(oCount), 32'd0);
        chk("rst empty", 32'(oEmpty), 32'd1);
        chk("rst full", 32'(oFull), 32'd0);
        chk("rst afull", 32'(oAlmostFull), 32'd0);
        chk("rst valid", 32'(oValid), 32'd0);
        chk("rst dout", 32'(oDataOut), 32'd0);
        chk("rst ovf", 32'(oOverflow), 32'd0);
        chk("rst unf", 32'(oUnderflow), 32'd0);
        #10 Reset = 1'b1;
        @(posedge Clock); #1;

        // Basic ordering
        step("p11", 1, 8'h11, 0, 0);
        step("p22", 1, 8'h22, 0, 0);
        step("p33", 1, 8'h33, 0, 0);
        repeat (3) step("pop3", 0, 8'h00, 1, 0);
        step("idle", 0, 8'h00, 0, 0);

        // Fill to full, then a rejected push
        for (int i = 0; i < Depth; i++) step("fill", 1, 8'(8'h40 + i), 0, 0);
        step("push17", 1, 8'hEE, 0, 0);
        step("clr_ovf", 0, 8'h00, 0, 1);

        // Push+pop at full, then drain: 0xAA must come out last
        step("full_pp", 1, 8'hAA, 1, 0);
        for (int i = 0; i < Depth; i++) step("drain", 0, 8'h00, 1, 0);
        step("idle", 0, 8'h00, 0, 0);

        // Push+pop at empty: only the push lands
        step("empty_pp", 1, 8'h5C, 1, 0);
        step("clr_unf", 0, 8'h00, 0, 1);
        step("pop5c", 0, 8'h00, 1, 0);
        step("idle", 0, 8'h00, 0, 0);

        // Steady-state streaming at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) step("pre", 1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 40; i++) step("stream", 1, 8'(8'hA0 + i), 1, 0);
        repeat (3) step("post", 0, 8'h00, 1, 0);
        step("idle", 0, 8'h00, 0, 0);

        // Asynchronous reset with stored words
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 8'(8'hD0 + i), 0, 0);
        #2 Reset = 1'b0;
        #1;
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("arst count", 32'(oCount), 32'd0);
        chk("arst empty", 32'(oEmpty), 32'd1);
        chk("arst valid", 32'(oValid), 32'd0);
        chk("arst dout", 32'(oDataOut), 32'd0);
        @(posedge Clock); #3;
        Reset = 1'b1;
        @(posedge Clock); #1;
        step("new71", 1, 8'h71, 0, 0);
        step("new72", 1, 8'h72, 0, 0);
        repeat (2) step("newpop", 0, 8'h00, 1, 0);
        repeat (2) step("idle", 0, 8'h00, 0, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
